// File: rtl/mant_mul_seq.sv
// mant_mul_seq: sequential 24x24 unsigned mantissa multiplier.
// The operands are split into three bytes each. The nine byte pairs go through an
// external combinational 8x8 multiplier, one pair per cycle, and the shifted
// partial products are summed into a 48-bit accumulator.
// MUL_REG=1 registers each partial product for one cycle before it is added, so the
// last term is added in an extra FLUSH cycle.
// Optional feature: define MANT_ZERO_SKIP_EN so that a zero operand goes straight
// from IDLE to DONE with product 0.
module mant_mul_seq #(
    parameter int unsigned MUL_REG = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] a_in,
    input  logic [23:0] b_in,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [47:0] product,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    input  logic [15:0] mul_p
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [3:0]  k_q, k_d;
    logic [23:0] a_q, a_d, b_q, b_d;
    logic [47:0] acc_q, acc_d;
    logic [47:0] product_q, product_d;
    logic [47:0] pterm_q;
    logic        pval_q;
    logic [1:0]  i_sel, j_sel;
    logic [2:0]  lane;
    logic [47:0] term;
    logic [47:0] add;
    logic        zero_skip;

`ifdef MANT_ZERO_SKIP_EN
    assign zero_skip = (a_in == 24'd0) || (b_in == 24'd0);
`else
    assign zero_skip = 1'b0;
`endif

    // Map step index k to byte lanes: i = k mod 3 (A byte), j = k div 3 (B byte).
    always_comb begin
        i_sel = 2'd0;
        j_sel = 2'd0;
        case (k_q)
            4'd0:    begin i_sel = 2'd0; j_sel = 2'd0; end
            4'd1:    begin i_sel = 2'd1; j_sel = 2'd0; end
            4'd2:    begin i_sel = 2'd2; j_sel = 2'd0; end
            4'd3:    begin i_sel = 2'd0; j_sel = 2'd1; end
            4'd4:    begin i_sel = 2'd1; j_sel = 2'd1; end
            4'd5:    begin i_sel = 2'd2; j_sel = 2'd1; end
            4'd6:    begin i_sel = 2'd0; j_sel = 2'd2; end
            4'd7:    begin i_sel = 2'd1; j_sel = 2'd2; end
            4'd8:    begin i_sel = 2'd2; j_sel = 2'd2; end
            default: begin i_sel = 2'd0; j_sel = 2'd0; end
        endcase
    end

    // Byte operands to the external multiplier; held at zero outside RUN.
    always_comb begin
        mul_a = 8'd0;
        mul_b = 8'd0;
        if (state_q == RUN) begin
            case (i_sel)
                2'd0:    mul_a = a_q[7:0];
                2'd1:    mul_a = a_q[15:8];
                default: mul_a = a_q[23:16];
            endcase
            case (j_sel)
                2'd0:    mul_b = b_q[7:0];
                2'd1:    mul_b = b_q[15:8];
                default: mul_b = b_q[23:16];
            endcase
        end
    end

    // Partial product aligned to byte weight i+j, and the term added this cycle.
    always_comb begin
        lane = {1'b0, i_sel} + {1'b0, j_sel};
        term = {32'd0, mul_p} << {lane, 3'b000};
        add  = 48'd0;
        if (MUL_REG != 0) begin
            if (pval_q) begin
                add = pterm_q;
            end
        end else if (state_q == RUN) begin
            add = term;
        end
    end

    // Next-state logic: sequencing, operand capture, accumulation and product load.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q + add;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                acc_d = 48'd0;
                if (start) begin
                    a_d = a_in;
                    b_d = b_in;
                    k_d = 4'd0;
                    if (zero_skip) begin
                        state_d   = DONE;
                        product_d = 48'd0;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                k_d = k_q + 4'd1;
                if (k_q == 4'd8) begin
                    k_d = 4'd0;
                    if (MUL_REG != 0) begin
                        state_d = FLUSH;
                    end else begin
                        state_d   = DONE;
                        product_d = acc_d;
                    end
                end
            end
            FLUSH: begin
                state_d   = DONE;
                product_d = acc_d;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            k_q       <= 4'd0;
            a_q       <= 24'd0;
            b_q       <= 24'd0;
            acc_q     <= 48'd0;
            product_q <= 48'd0;
            pterm_q   <= 48'd0;
            pval_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            pterm_q   <= term;
            pval_q    <= (state_q == RUN);
        end
    end

    assign ready   = (state_q == IDLE);
    assign busy    = (state_q == RUN) || (state_q == FLUSH);
    assign done    = (state_q == DONE);
    assign product = product_q;

endmodule
